// File: rtl/dec_gpr_bank_ctl.sv
// dec_gpr_bank_ctl: multi-bank GPR file with bank-switch/clone engine; GPR_WR_BYPASS_EN enables write-to-read bypass
module dec_gpr_bank_ctl #(
  parameter int XLEN       = 32,
  parameter int NRD        = 4,
  parameter int NWR        = 3,
  parameter int BANKS      = 4,
  parameter int BANKS_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0]         i_rden,
  input  logic [NRD*5-1:0]       i_raddr,
  output logic [NRD*XLEN-1:0]    o_rd,
  input  logic [NWR-1:0]         i_wen,
  input  logic [NWR*5-1:0]       i_waddr,
  input  logic [NWR*XLEN-1:0]    i_wd,
  input  logic                   i_bank_sw_req,
  input  logic [BANKS_LOG2-1:0]  i_bank_sw_id,
  input  logic                   i_bank_sw_clone,
  output logic                   o_bank_sw_ack,
  output logic                   o_busy,
  output logic [BANKS_LOG2-1:0]  o_active_bank,
  input  logic                   i_scan_mode
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_COPY = 1'b1;
  logic [XLEN-1:0]       r_gpr [BANKS][32];
  logic                  r_state;
  logic [4:0]            r_ptr;
  logic [BANKS_LOG2-1:0] r_active;
  logic [BANKS_LOG2-1:0] r_target;
  logic                  r_ack;
  logic                  w_sw_ok;
  logic                  w_unused;
  assign w_unused      = i_scan_mode;
  assign w_sw_ok       = i_bank_sw_req && (int'(i_bank_sw_id) < BANKS);
  assign o_bank_sw_ack = r_ack;
  assign o_busy        = r_state == S_COPY;
  assign o_active_bank = r_active;
  // Switch/clone FSM: plain switches complete in one edge, clones walk x1..x31
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 5'd1;
      r_active <= '0;
      r_target <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_sw_ok && i_bank_sw_clone && i_bank_sw_id != r_active) begin
          r_target <= i_bank_sw_id;
          r_ptr    <= 5'd1;
          r_state  <= S_COPY;
        end else if (w_sw_ok) begin
          r_active <= i_bank_sw_id;
          r_ack    <= 1'b1;
        end
      end else if (r_ptr == 5'd31) begin
        r_active <= r_target;
        r_ptr    <= 5'd1;
        r_state  <= S_IDLE;
        r_ack    <= 1'b1;
      end else begin
        r_ptr <= r_ptr + 5'd1;
      end
    end
  end
  // Register storage: later assignments win, so writes override the copy and higher ports override lower
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int r = 0; r < 32; r++)
          r_gpr[b][r] <= '0;
    end else begin
      if (r_state == S_COPY)
        r_gpr[r_target][r_ptr] <= r_gpr[r_active][r_ptr];
      for (int p = 0; p < NWR; p++) begin
        if (i_wen[p] && i_waddr[p*5+:5] != 5'd0) begin
          r_gpr[r_active][i_waddr[p*5+:5]] <= i_wd[p*XLEN+:XLEN];
          if (r_state == S_COPY)
            r_gpr[r_target][i_waddr[p*5+:5]] <= i_wd[p*XLEN+:XLEN];
        end
      end
    end
  end
  // Combinational reads from the active bank; x0 and disabled ports read 0
  always_comb begin
    o_rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (i_rden[i] && i_raddr[i*5+:5] != 5'd0) begin
        o_rd[i*XLEN+:XLEN] = r_gpr[r_active][i_raddr[i*5+:5]];
`ifdef GPR_WR_BYPASS_EN
        for (int p = 0; p < NWR; p++)
          if (i_wen[p] && i_waddr[p*5+:5] == i_raddr[i*5+:5])
            o_rd[i*XLEN+:XLEN] = i_wd[p*XLEN+:XLEN];
`endif
      end
    end
  end
endmodule
